// File: rtl/sample_packer_ppl.sv
// sample_packer_ppl: serial-to-parallel packer feeding the pipelined adder tree.
// Collects signed samples into a DATA_NUM-slot word; a frame-end marker flushes
// partial groups with zero padding. No backpressure; one cycle of latency.
// Optional build macro: SAMPLE_PACKER_SLIDING_EN selects sliding-window (moving-sum)
// mode instead of the default block mode.
module sample_packer_ppl #(
  parameter int unsigned DATA_I_WIDTH = 8,
  parameter int unsigned DATA_NUM     = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 din_valid,
  input  logic                                 din_last,
  input  logic [DATA_I_WIDTH-1:0]              din_data,
  output logic                                 dout_valid,
  output logic                                 dout_last,
  output logic [$clog2(DATA_NUM+1)-1:0]        dout_fill,
  output logic [DATA_NUM*DATA_I_WIDTH-1:0]     dout_data
);

  localparam int unsigned W  = DATA_I_WIDTH;
  localparam int unsigned DW = DATA_NUM * DATA_I_WIDTH;
  localparam int unsigned CW = $clog2(DATA_NUM + 1);

  logic [DW-1:0] slots_q, slots_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] word_c;
  logic [CW-1:0] fill_c;
  logic          emit_c;

`ifdef SAMPLE_PACKER_SLIDING_EN
  logic          full_c;

  // Sliding window: shift new sample into the top slot, emit once the window is full
  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    word_c  = {din_data, slots_q[DW-1:W]};
    full_c  = (cnt_q >= CW'(DATA_NUM - 1));
    fill_c  = full_c ? CW'(DATA_NUM) : CW'(cnt_q + CW'(1));
    emit_c  = 1'b0;
    if (din_valid) begin
      emit_c = full_c || din_last;
      if (din_last) begin
        slots_d = '0;
        cnt_d   = '0;
      end else begin
        slots_d = word_c;
        cnt_d   = full_c ? CW'(DATA_NUM) : CW'(cnt_q + CW'(1));
      end
    end
  end
`else
  // Block mode: write sample into slot cnt, emit on full group or frame end
  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    word_c  = slots_q;
    fill_c  = CW'(cnt_q + CW'(1));
    emit_c  = 1'b0;
    if (din_valid) begin
      for (int k = 0; k < int'(DATA_NUM); k++) begin
        if (CW'(k) == cnt_q) word_c[k*W +: W] = din_data;
      end
      if ((cnt_q == CW'(DATA_NUM - 1)) || din_last) begin
        emit_c  = 1'b1;
        slots_d = '0;
        cnt_d   = '0;
      end else begin
        slots_d = word_c;
        cnt_d   = CW'(cnt_q + CW'(1));
      end
    end
  end
`endif

  // Slot history and fill counter; reset discards any partial group
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs: strobe every cycle, payload held between emits
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_fill  <= '0;
      dout_data  <= '0;
    end else begin
      dout_valid <= emit_c;
      if (emit_c) begin
        dout_last <= din_last;
        dout_fill <= fill_c;
        dout_data <= word_c;
      end
    end
  end

endmodule

// File: doc/sample_packer_ppl.md
# sample_packer_ppl

Serial-to-parallel packer that collects a stream of signed samples into the packed `DATA_NUM`-slot vector consumed by the pipelined adder tree. It sits directly upstream of the adder tree: its `dout_valid`/`dout_data` connect straight to the tree's `din_valid`/`din_data`. A frame-end marker flushes partial groups with zero padding and is carried alongside the output. The block exerts no backpressure.

## Interface
- `DATA_I_WIDTH`, 8, sample width in bits (signed two's complement)
- `DATA_NUM`, 5, number of slots in the packed output word (≥2)
- `clk`  input  1  clock; all logic rising-edge
- `rst`  input  1  reset, synchronous, active-high
- `din_valid`  input  1  sample strobe; one sample accepted per cycle while high
- `din_last`  input  1  frame end; qualified by `din_valid`, marks the accepted sample as the frame's last
- `din_data`  input  DATA_I_WIDTH  signed sample
- `dout_valid`  output  1  one-cycle strobe, packed word available
- `dout_last`  output  1  word contains the frame's last sample; qualified by `dout_valid`
- `dout_fill`  output  $clog2(DATA_NUM+1)  number of real (non-pad) samples in the word, 1..DATA_NUM
- `dout_data`  output  DATA_NUM*DATA_I_WIDTH  packed word; slot k = bits [(k+1)*DATA_I_WIDTH-1 : k*DATA_I_WIDTH]

## Operation
- Internal state: slot register array (`DATA_NUM` × `DATA_I_WIDTH`) and fill counter `cnt` (0..DATA_NUM-1 in block mode, 0..DATA_NUM in sliding mode).
- Block mode (default):
  - An accepted sample is written to slot `cnt`, and `cnt` increments.
  - When the sample fills slot DATA_NUM-1, or `din_last`=1, the word is emitted. On emit:
    - slots above the last written one read 0;
    - `dout_fill` = cnt+1;
    - `dout_last` = `din_last`;
    - `cnt` returns to 0 and the slot array is cleared to 0.
  - Slot 0 always holds the earliest sample of the group.
  - `din_last` together with a full group gives a single emit with `dout_fill`=DATA_NUM and `dout_last`=1.
  - Cycles with `din_valid`=0 hold state. `din_last` without `din_valid` is ignored.
- Outputs are registered. `dout_valid` is low on every cycle without an emit. `dout_data`, `dout_fill` and `dout_last` hold their last value between emits.
- Signedness: samples are stored unmodified with no extension. Pad slots are exactly zero.

## Timing
- Reset values: `dout_valid`=0, `dout_last`=0, `dout_fill`=0, `dout_data`=0; `cnt`=0; slot array 0.
- Latency: the emitting sample accepted at edge n gives `dout_valid`=1 during the cycle after edge n (1-cycle latency).
- Throughput: one sample per cycle sustained. In block mode, a new group starts accumulating on the same edge that emits the previous one, with no bubble.
- Reset mid-group discards the partial group with no emit. `rst` has priority over `din_valid`.
- Downstream tree latency is added externally. This block adds exactly 1 cycle.

## Configuration
- `SAMPLE_PACKER_SLIDING_EN` defined (sliding-window mode, for moving-sum use):
  - Slots form a shift register: each accepted sample enters slot DATA_NUM-1 and shifts existing contents toward slot 0. Slot 0 is the oldest.
  - `cnt` saturates at DATA_NUM.
  - Once `cnt` reaches DATA_NUM, every accepted sample emits a word with `dout_fill`=DATA_NUM.
  - Before the window is full, a sample emits only if `din_last`=1. That word has its low (oldest) slots zero and `dout_fill`=cnt+1.
  - On `din_last`, the emit happens and then the history and `cnt` clear to 0.
- Undefined: block mode as above. Sliding logic is not compiled.

## Test plan
- DATA_NUM=5, W=8, block mode. Feed 1,2,3,4,5 on consecutive cycles -> one `dout_valid` pulse 1 cycle after sample 5; slots 0..4 = 1,2,3,4,5; `dout_fill`=5; `dout_last`=0.
- Block mode, 7 samples (-1,-2,…,-7) with `din_last` on -7 -> first word -1..-5 (fill 5, last 0); second word slots -6,-7,0,0,0 (fill 2, last 1), emitted exactly 2 cycles after the first.
- Block mode, valid gaps: samples 10,_,20,_,_,30,40,50 (`_` = `din_valid` low) -> single word 10,20,30,40,50 after 50; no spurious `dout_valid`.
- Block mode, `rst` pulse after 3 samples, then 5 new samples 6..10 -> the word is 6..10 only; all outputs 0 during and after reset until the emit.
- Sliding mode, DATA_NUM=3: samples 1,2,3,4 then 5 with `din_last` -> words (1,2,3), (2,3,4), (3,4,5), the last one with `dout_last`=1. A following sample 9 with `din_last` -> word (0,0,9), fill 1.
- Sliding mode, back-to-back stream of 100 samples -> 98 consecutive `dout_valid` cycles. Each word equals the previous one shifted by one slot.
